// File: rtl/gen_scheduler.sv
// rtl/gen_scheduler.sv - Game of Life generation scheduler and world-memory arbiter
module gen_scheduler #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              clear,
  input  logic [CNT_W-1:0]  gen_limit,
  output logic              auto_en,
  input  logic [ADDR_W-1:0] auto_row,
  input  logic [ADDR_W-1:0] auto_col,
  input  logic              auto_we,
  input  logic              auto_wdata,
  output logic              auto_rdata,
  input  logic              auto_update_done,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_row,
  input  logic [ADDR_W-1:0] host_col,
  input  logic              host_we,
  input  logic              host_wdata,
  output logic              host_gnt,
  output logic              host_rdata,
  output logic              host_valid,
  output logic [ADDR_W-1:0] mem_row,
  output logic [ADDR_W-1:0] mem_col,
  output logic              mem_we,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic [CNT_W-1:0]  gen_count,
  output logic              gen_done,
  output logic              limit_hit,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  state_t             r_state;
  logic               r_auto_en;
  logic               r_busy;
  logic               r_gen_done;
  logic               r_limit_hit;
  logic               r_step_pend;
  logic               r_host_rdata;
  logic               r_host_valid;
  logic [CNT_W-1:0]   r_gen_count;

  logic               w_host_gnt;
  logic               w_host_rd;
  logic               w_start;
  logic [CNT_W-1:0]   w_count_inc;

  // Grant is gated by rst_n so the host never sees a grant while reset is held.
  assign w_host_gnt  = rst_n && (r_state == S_IDLE) && host_req;
  assign w_host_rd   = w_host_gnt && !host_we;
  // A clear in the same IDLE cycle lifts the limit block for this start decision.
  assign w_start     = (r_state == S_IDLE) && !host_req && (run || r_step_pend) &&
                       (!r_limit_hit || clear);
  assign w_count_inc = r_gen_count + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_auto_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_gen_done   <= 1'b0;
      r_limit_hit  <= 1'b0;
      r_step_pend  <= 1'b0;
      r_host_rdata <= 1'b0;
      r_host_valid <= 1'b0;
      r_gen_count  <= '0;
    end else begin
      r_gen_done   <= 1'b0;
      r_host_valid <= w_host_rd;
      if (w_host_rd) r_host_rdata <= mem_rdata;
      if (step) r_step_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_gen_count <= '0;
            r_limit_hit <= 1'b0;
          end
          if (w_start) begin
            r_state   <= S_GEN;
            r_auto_en <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_GEN: begin
          if (auto_update_done) begin
            r_state     <= S_DONE;
            r_auto_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_gen_done  <= 1'b1;
            r_step_pend <= 1'b0;
          end
        end
        S_DONE: begin
          r_gen_count <= w_count_inc;
          if ((gen_limit != '0) && (w_count_inc == gen_limit)) r_limit_hit <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_row    = '0;
    mem_col    = '0;
    mem_we     = 1'b0;
    mem_wdata  = 1'b0;
    auto_rdata = 1'b0;
    if (r_auto_en) begin
      mem_row    = auto_row;
      mem_col    = auto_col;
      mem_we     = auto_we;
      mem_wdata  = auto_wdata;
      auto_rdata = mem_rdata;
    end else if (w_host_gnt) begin
      mem_row   = host_row;
      mem_col   = host_col;
      mem_we    = host_we;
      mem_wdata = host_wdata;
    end
  end

  assign auto_en    = r_auto_en;
  assign busy       = r_busy;
  assign gen_done   = r_gen_done;
  assign limit_hit  = r_limit_hit;
  assign gen_count  = r_gen_count;
  assign host_gnt   = w_host_gnt;
  assign host_rdata = r_host_rdata;
  assign host_valid = r_host_valid;

endmodule

// File: tb/tb_gen_scheduler.sv
// tb/tb_gen_scheduler.sv - scoreboard bench for gen_scheduler with world memory and automaton models
module tb_gen_scheduler;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n, run, step, clear;
  logic [CNT_W-1:0] gen_limit;
  logic auto_en, auto_we, auto_wdata, auto_rdata, auto_update_done;
  logic [ADDR_W-1:0] auto_row, auto_col, host_row, host_col, mem_row, mem_col;
  logic host_req, host_we, host_wdata, host_gnt, host_rdata, host_valid;
  logic mem_we, mem_wdata, mem_rdata;
  logic [CNT_W-1:0] gen_count;
  logic gen_done, limit_hit, busy;

  logic [4095:0] world = '0;
  int checks = 0, failures = 0;
  int gen_len = 100, a_cnt = 0;
  logic auto_val = 1'b1;
  logic [CNT_W-1:0] exp_gen_q[$];
  logic exp_rd_q[$];
  int gen_done_cnt = 0, en_cycles = 0;
  logic chk_cnt_next = 1'b0, prev_rd_gnt = 1'b0;
  int b_en, b_done;

  always #5 clk = ~clk;

  gen_scheduler #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear(clear), .gen_limit(gen_limit),
    .auto_en(auto_en), .auto_row(auto_row), .auto_col(auto_col), .auto_we(auto_we),
    .auto_wdata(auto_wdata), .auto_rdata(auto_rdata), .auto_update_done(auto_update_done),
    .host_req(host_req), .host_row(host_row), .host_col(host_col), .host_we(host_we),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_valid(host_valid), .mem_row(mem_row), .mem_col(mem_col), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .gen_count(gen_count),
    .gen_done(gen_done), .limit_hit(limit_hit), .busy(busy)
  );

  assign mem_rdata = world[{mem_row, mem_col}];
  always @(posedge clk) if (mem_we) world[{mem_row, mem_col}] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (gen_done_cnt >= n) ok = 1;
    end
    if (!ok) chk("timeout_gen_done", gen_done_cnt, n);
  endtask

  task automatic wait_en(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (auto_en) ok = 1;
    end
    if (!ok) chk("timeout_auto_en", 0, 1);
    cyc();
  endtask

  // Automaton model: writes cell (5,7) on its second enabled cycle, finishes after gen_len cycles.
  initial begin
    auto_update_done = 0; auto_we = 0; auto_row = 0; auto_col = 0; auto_wdata = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !auto_en) begin
        a_cnt = 0; auto_update_done = 0; auto_we = 0; auto_row = 1; auto_col = 1;
      end else begin
        a_cnt++;
        auto_update_done = (a_cnt == gen_len);
        auto_we    = (a_cnt == 2);
        auto_row   = auto_we ? 6'd5 : 6'd1;
        auto_col   = auto_we ? 6'd7 : 6'd1;
        auto_wdata = auto_val;
      end
    end
  end

  // Monitor: pops expected count after each gen_done and expected data on each host_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en) en_cycles++;
      if (chk_cnt_next) begin
        chk_cnt_next = 0;
        if (exp_gen_q.size() == 0) chk("unexpected_gen_done", 1, 0);
        else chk("gen_count_after_done", gen_count, exp_gen_q.pop_front());
      end
      if (gen_done) begin
        gen_done_cnt++;
        chk_cnt_next = 1;
      end
      if (host_valid || prev_rd_gnt) chk("host_valid_timing", host_valid, prev_rd_gnt);
      if (host_valid) begin
        if (exp_rd_q.size() == 0) chk("unexpected_host_valid", 1, 0);
        else chk("host_rdata", host_rdata, exp_rd_q.pop_front());
      end
      prev_rd_gnt = host_gnt && !host_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1; run = 0; step = 0; clear = 0; gen_limit = 0;
    host_req = 0; host_row = 0; host_col = 0; host_we = 0; host_wdata = 0;
    #1 rst_n = 0;
    #2;
    chk("rst_auto_en", auto_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gen_count", gen_count, 0);
    chk("rst_limit_hit", limit_hit, 0);
    chk("rst_gnt_valid_done_we", {host_gnt, host_valid, gen_done, mem_we}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc();

    // Single step, 100-cycle generation
    b_en = en_cycles; b_done = gen_done_cnt;
    exp_gen_q.push_back(1);
    step = 1; cyc(); step = 0;
    wait_done(b_done + 1, 300);
    repeat (5) cyc();
    chk("step_en_cycles", en_cycles - b_en, 100);
    chk("step_done_pulses", gen_done_cnt - b_done, 1);
    chk("step_busy_after", busy, 0);
    chk("step_count", gen_count, 1);

    // Host read of (5,7) raised mid-generation; generation writes 0 over the earlier 1
    gen_len = 20; auto_val = 0; b_done = gen_done_cnt;
    exp_gen_q.push_back(2);
    step = 1; cyc(); step = 0;
    wait_en(10);
    repeat (3) cyc();
    host_req = 1; host_we = 0; host_row = 5; host_col = 7;
    begin
      bit bad = 0, got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clk);
        if (auto_en || gen_done) bad |= host_gnt;
        else if (host_gnt) got = 1;
      end
      chk("gnt_blocked_in_gen", bad, 0);
      chk("gnt_after_gen", got, 1);
      chk("gnt_after_done", gen_done_cnt - b_done, 1);
    end
    exp_rd_q.push_back(1'b0);
    cyc(); host_req = 0;
    cyc();

    // Back-to-back host write then reads
    host_req = 1; host_we = 1; host_row = 10; host_col = 20; host_wdata = 1;
    cyc();
    host_we = 0; exp_rd_q.push_back(1'b1);
    cyc();
    host_col = 21; exp_rd_q.push_back(1'b0);
    cyc();
    host_req = 0;
    repeat (2) cyc();

    clear = 1; cyc(); clear = 0;
    chk("clear_count", gen_count, 0);

    // Host priority, then limit of 3
    gen_limit = 3; gen_len = 10; run = 1; b_en = en_cycles; b_done = gen_done_cnt;
    host_req = 1; host_we = 0; host_row = 0; host_col = 0;
    for (int i = 0; i < 6; i++) begin
      exp_rd_q.push_back(1'b0);
      cyc();
    end
    host_req = 0;
    chk("prio_no_gen", en_cycles - b_en, 0);
    for (int k = 1; k <= 3; k++) exp_gen_q.push_back(k[CNT_W-1:0]);
    @(negedge clk); chk("prio_release_idle", auto_en, 0);
    @(negedge clk); chk("prio_start_next", auto_en, 1);
    wait_done(b_done + 3, 200);
    repeat (3) cyc();
    chk("limit_hit_set", limit_hit, 1);
    b_en = en_cycles;
    repeat (20) cyc();
    chk("limit_blocks_gen", en_cycles - b_en, 0);
    chk("limit_count", gen_count, 3);
    chk("limit_pulses", gen_done_cnt - b_done, 3);

    // Clear with run held: clear and start in the same cycle
    b_done = gen_done_cnt;
    exp_gen_q.push_back(1);
    clear = 1; cyc(); clear = 0;
    chk("resume_count_cleared", gen_count, 0);
    chk("resume_limit_cleared", limit_hit, 0);
    chk("resume_started", auto_en, 1);
    cyc(); run = 0;
    wait_done(b_done + 1, 100);
    repeat (4) cyc();
    chk("resume_count", gen_count, 1);

    // Wrap at 2^CNT_W-1 -> 0 with unlimited limit
    gen_limit = 0; gen_len = 2;
    clear = 1; cyc(); clear = 0;
    chk("wrap_pre_count", gen_count, 0);
    for (int k = 1; k <= 16; k++) exp_gen_q.push_back(k[CNT_W-1:0]);
    b_done = gen_done_cnt;
    run = 1;
    wait_done(b_done + 16, 200);
    cyc(); run = 0;
    repeat (3) cyc();
    chk("wrap_count", gen_count, 0);
    chk("wrap_limit_hit", limit_hit, 0);
    chk("wrap_pulses", gen_done_cnt - b_done, 16);

    // Reset asserted mid-generation with a pending step
    exp_gen_q.push_back(1);
    step = 1; cyc(); step = 0;
    b_done = gen_done_cnt;
    wait_done(b_done + 1, 50);
    repeat (3) cyc();
    gen_len = 50;
    step = 1; cyc(); step = 0;
    wait_en(10);
    repeat (3) cyc();
    step = 1; cyc(); step = 0;
    repeat (3) cyc();
    #2 rst_n = 0;
    #1;
    chk("rstgen_auto_en", auto_en, 0);
    chk("rstgen_busy", busy, 0);
    chk("rstgen_count", gen_count, 0);
    chk("rstgen_we_gnt", {mem_we, host_gnt}, 0);
    repeat (2) cyc();
    rst_n = 1;
    b_en = en_cycles;
    repeat (15) cyc();
    chk("rstgen_step_lost", en_cycles - b_en, 0);

    repeat (3) cyc();
    chk("queues_drained", exp_gen_q.size() + exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
